// File: rtl/pipeline_pkg.sv
// Shared constants and types for the pipeline hazard controller: forwarding
// select codes, the mult/div timer state encoding and the hardwired zero register.
package pipeline_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {IDLE, BUSY} muldiv_state_t;

  // M wins over W; a write to $zero is never a forwarding source.
  function automatic logic [1:0] fwd_sel(
    input logic       rw_m,
    input logic [4:0] wr_m,
    input logic       rw_w,
    input logic [4:0] wr_w,
    input logic [4:0] src
  );
    if (rw_m && (wr_m != REG_ZERO) && (wr_m == src)) return FWD_M;
    if (rw_w && (wr_w != REG_ZERO) && (wr_w == src)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/muldiv_timer.sv
// Tracks the multi-cycle mult/div unit: busy for MULDIV_LAT cycles after each
// start, a start while busy restarts the full latency.
module muldiv_timer
  import pipeline_pkg::*;
#(
  parameter int MULDIV_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  // Keep at least one counter bit so MULDIV_LAT=1 still elaborates.
  localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MULDIV_LAT - 1);

  muldiv_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= BUSY;
            cnt_q   <= RELOAD;
          end
        end
        BUSY: begin
          if (start) begin
            cnt_q <= RELOAD;
          end else if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy = (state_q == BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stall/flush
// control, execute-stage forwarding selects and a saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MULDIV_LAT = 32,
  parameter int STALL_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         rs_d,
  input  logic [4:0]         rt_d,
  input  logic               uses_rs_d,
  input  logic               uses_rt_d,
  input  logic               hilo_use_d,
  input  logic               branch_taken_d,
  input  logic [4:0]         rs_e,
  input  logic [4:0]         rt_e,
  input  logic [4:0]         wr_reg_e,
  input  logic [4:0]         wr_reg_m,
  input  logic [4:0]         wr_reg_w,
  input  logic               reg_write_e,
  input  logic               reg_write_m,
  input  logic               reg_write_w,
  input  logic               mem_to_reg_e,
  input  logic               muldiv_start_e,
  input  logic               imem_ready,
  input  logic               stat_clr,
  output logic               pc_enable,
  output logic               haz_enable_fd,
  output logic               sig_clr_fd,
  output logic               sig_clr_de,
  output logic [1:0]         fwd_a_e,
  output logic [1:0]         fwd_b_e,
  output logic               muldiv_busy,
  output logic [STALL_W-1:0] stall_cycles
);

  logic               luh;
  logic               hh;
  logic [STALL_W-1:0] stall_q;
  logic [STALL_W-1:0] stall_d;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  muldiv_timer #(
    .MULDIV_LAT(MULDIV_LAT)
  ) u_muldiv_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(muldiv_start_e),
    .busy (muldiv_busy)
  );

  assign luh = mem_to_reg_e && reg_write_e && (wr_reg_e != REG_ZERO) &&
               ((uses_rs_d && (wr_reg_e == rs_d)) || (uses_rt_d && (wr_reg_e == rt_d)));
  assign hh  = muldiv_busy && hilo_use_d;

  // Reset holds the front end flushed; otherwise first matching hazard row wins.
  always_comb begin
    pc_enable     = 1'b1;
    haz_enable_fd = 1'b1;
    sig_clr_fd    = 1'b0;
    sig_clr_de    = 1'b0;
    fwd_a_e       = FWD_RF;
    fwd_b_e       = FWD_RF;
    if (!rst_n) begin
      pc_enable  = 1'b0;
      sig_clr_fd = 1'b1;
      sig_clr_de = 1'b1;
    end else begin
      fwd_a_e = fwd_sel(reg_write_m, wr_reg_m, reg_write_w, wr_reg_w, rs_e);
      fwd_b_e = fwd_sel(reg_write_m, wr_reg_m, reg_write_w, wr_reg_w, rt_e);
      if (luh || hh) begin
        pc_enable     = 1'b0;
        haz_enable_fd = 1'b0;
        sig_clr_de    = 1'b1;
      end else if (branch_taken_d) begin
        sig_clr_fd = 1'b1;
      end else if (!imem_ready) begin
        pc_enable  = 1'b0;
        sig_clr_fd = 1'b1;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (stat_clr)        stall_d = '0;
    else if (!pc_enable) stall_d = sat_inc(stall_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios plus random
// traffic, checked against a cycle-numbered behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int LAT = 4;
  localparam int SW  = 5;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_reg_e, wr_reg_m, wr_reg_w;
  logic uses_rs_d, uses_rt_d, hilo_use_d, branch_taken_d;
  logic reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e;
  logic muldiv_start_e, imem_ready, stat_clr;
  logic pc_enable, haz_enable_fd, sig_clr_fd, sig_clr_de, muldiv_busy;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [SW-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULDIV_LAT(LAT), .STALL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d), .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
    .hilo_use_d(hilo_use_d), .branch_taken_d(branch_taken_d),
    .rs_e(rs_e), .rt_e(rt_e),
    .wr_reg_e(wr_reg_e), .wr_reg_m(wr_reg_m), .wr_reg_w(wr_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .muldiv_start_e(muldiv_start_e),
    .imem_ready(imem_ready), .stat_clr(stat_clr),
    .pc_enable(pc_enable), .haz_enable_fd(haz_enable_fd),
    .sig_clr_fd(sig_clr_fd), .sig_clr_de(sig_clr_de),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
  );

  typedef struct {
    string tag;
    logic pc, en, cfd, cde, busy;
    logic [1:0] fa, fb;
    int sc;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_err = 0;

  // Model state: cycle number, cycle of the latest accepted start, stall count.
  int cyc = 0;
  int last_start = -1000;
  int sc_model = 0;
  bit stim_done = 0;

  task automatic chk(string tag, string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0h expected %0h (t=%0t)", tag, nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(logic [4:0] src);
    if (reg_write_m && wr_reg_m != 0 && wr_reg_m == src) return 2'b10;
    if (reg_write_w && wr_reg_w != 0 && wr_reg_w == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clr_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    wr_reg_e = 0; wr_reg_m = 0; wr_reg_w = 0;
    uses_rs_d = 0; uses_rt_d = 0; hilo_use_d = 0; branch_taken_d = 0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0; mem_to_reg_e = 0;
    muldiv_start_e = 0; imem_ready = 1; stat_clr = 0;
  endtask

  task automatic rand_inputs();
    rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
    rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
    wr_reg_e = 5'($urandom_range(0, 3)); wr_reg_m = 5'($urandom_range(0, 3));
    wr_reg_w = 5'($urandom_range(0, 3));
    uses_rs_d = 1'($urandom); uses_rt_d = 1'($urandom);
    hilo_use_d = ($urandom_range(0, 3) == 0);
    branch_taken_d = ($urandom_range(0, 4) == 0);
    reg_write_e = 1'($urandom); reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
    mem_to_reg_e = ($urandom_range(0, 2) == 0);
    muldiv_start_e = ($urandom_range(0, 9) == 0);
    imem_ready = ($urandom_range(0, 4) != 0);
    stat_clr = ($urandom_range(0, 19) == 0);
  endtask

  // Called with this cycle's inputs applied; records expectations, advances one edge.
  task automatic step(string tag);
    exp_t e;
    bit luh, hh, busy;
    e.tag = tag;
    busy = (cyc > last_start) && (cyc <= last_start + LAT);
    luh = mem_to_reg_e && reg_write_e && wr_reg_e != 0 &&
          ((uses_rs_d && wr_reg_e == rs_d) || (uses_rt_d && wr_reg_e == rt_d));
    hh = busy && hilo_use_d;
    e.sc = sc_model;
    if (!rst_n) begin
      {e.pc, e.en, e.cfd, e.cde} = 4'b0111;
      e.fa = 0; e.fb = 0; e.busy = 0; e.sc = 0;
    end else begin
      e.busy = busy;
      e.fa = ref_fwd(rs_e);
      e.fb = ref_fwd(rt_e);
      if (luh || hh)            {e.pc, e.en, e.cfd, e.cde} = 4'b0001;
      else if (branch_taken_d)  {e.pc, e.en, e.cfd, e.cde} = 4'b1110;
      else if (!imem_ready)     {e.pc, e.en, e.cfd, e.cde} = 4'b0110;
      else                      {e.pc, e.en, e.cfd, e.cde} = 4'b1100;
    end
    q.push_back(e);
    if (!rst_n) begin
      last_start = -1000;
      sc_model = 0;
    end else begin
      if (muldiv_start_e) last_start = cyc;
      if (stat_clr) sc_model = 0;
      else if (!e.pc && sc_model < SMAX) sc_model++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(e.tag, "pc_enable", 32'(pc_enable), 32'(e.pc));
        chk(e.tag, "haz_enable_fd", 32'(haz_enable_fd), 32'(e.en));
        chk(e.tag, "sig_clr_fd", 32'(sig_clr_fd), 32'(e.cfd));
        chk(e.tag, "sig_clr_de", 32'(sig_clr_de), 32'(e.cde));
        chk(e.tag, "fwd_a_e", 32'(fwd_a_e), 32'(e.fa));
        chk(e.tag, "fwd_b_e", 32'(fwd_b_e), 32'(e.fb));
        chk(e.tag, "muldiv_busy", 32'(muldiv_busy), 32'(e.busy));
        chk(e.tag, "stall_cycles", 32'(stall_cycles), 32'(e.sc));
      end
    end
  end

  initial begin : stimulus
    clr_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    step("reset"); step("reset");
    rst_n = 1'b1;
    step("idle");

    // Load-use on $t0, then the load moves on to M.
    mem_to_reg_e = 1; reg_write_e = 1; wr_reg_e = 8; rs_d = 8; uses_rs_d = 1;
    step("luh");
    mem_to_reg_e = 0; reg_write_e = 0; wr_reg_e = 0;
    reg_write_m = 1; wr_reg_m = 8; rs_e = 8;
    step("luh_after");
    clr_inputs();

    reg_write_m = 1; reg_write_w = 1; wr_reg_m = 8; wr_reg_w = 8; rs_e = 8; rt_e = 8;
    step("fwd_m_pri");
    reg_write_m = 0;
    step("fwd_w");
    wr_reg_m = 0; wr_reg_w = 0; rs_e = 0; rt_e = 0; reg_write_m = 1;
    step("fwd_zero");
    clr_inputs();

    muldiv_start_e = 1;
    step("md_start");
    muldiv_start_e = 0; hilo_use_d = 1;
    for (int i = 0; i < LAT + 2; i++) step("md_hilo");
    clr_inputs();

    branch_taken_d = 1; imem_ready = 0;
    step("br_imem");
    mem_to_reg_e = 1; reg_write_e = 1; wr_reg_e = 3; rt_d = 3; uses_rt_d = 1;
    step("br_luh");
    clr_inputs();

    imem_ready = 0;
    for (int i = 0; i < 3; i++) step("imem_wait");
    imem_ready = 1;
    step("imem_back");
    imem_ready = 0; stat_clr = 1;
    step("stat_clr");
    clr_inputs();
    step("after_clr");

    muldiv_start_e = 1;
    step("md_restart0");
    muldiv_start_e = 0;
    step("md_mid"); step("md_mid");
    rst_n = 1'b0;
    step("rst_mid_busy");
    rst_n = 1'b1;
    step("post_rst"); step("post_rst");

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst_n = ($urandom_range(0, 99) != 0);
      step("random");
    end
    rst_n = 1'b1;
    clr_inputs();
    step("settle");

    imem_ready = 0;
    for (int i = 0; i < SMAX + 4; i++) step("saturate");
    clr_inputs();
    step("sat_hold");

    stim_done = 1;
  end

  initial begin : finisher
    int budget;
    budget = 20000;
    while (!stim_done && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (!stim_done || q.size() != 0) begin
      n_err++;
      $display("FAIL drain: stimulus done=%0d queue=%0d required done=1 queue=0", stim_done, q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It produces the PC enable, the F/D register enable and clear, the D/E bubble clear and the execute-stage forwarding selects. It tracks the multi-cycle multiply/divide unit with an internal FSM. It also keeps a saturating stall-cycle counter for performance measurement. It sits beside the datapath and drives `haz_enable` and `sig_clr` of the F/D pipeline register directly.

## Interface

Parameters:
- `MULDIV_LAT`, default 32: number of cycles HI/LO is busy after a mult/div issues; legal range is 1 or more.
- `STALL_W`, default 16: width of the stall counter.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `rs_d`, `rt_d`  in  5  source registers of the instruction in D
- `uses_rs_d`, `uses_rt_d`  in  1  D instruction reads rs / rt
- `hilo_use_d`  in  1  D instruction reads or writes HI/LO
- `branch_taken_d`  in  1  branch or jump resolved taken in D
- `rs_e`, `rt_e`  in  5  source registers of the instruction in E
- `wr_reg_e`, `wr_reg_m`, `wr_reg_w`  in  5  destination register per stage
- `reg_write_e`, `reg_write_m`, `reg_write_w`  in  1  stage writes the register file
- `mem_to_reg_e`  in  1  E instruction is a load
- `muldiv_start_e`  in  1  mult/div issues from E this cycle
- `imem_ready`  in  1  instruction memory returns a valid word this cycle
- `stat_clr`  in  1  synchronous clear of the stall counter
- `pc_enable`  out  1  PC register load enable
- `haz_enable_fd`  out  1  F/D register enable
- `sig_clr_fd`  out  1  F/D register clear (applies only while enabled)
- `sig_clr_de`  out  1  D/E register clear, which inserts a bubble
- `fwd_a_e`, `fwd_b_e`  out  2  E operand source: 00 = register file, 01 = W, 10 = M
- `muldiv_busy`  out  1  HI/LO result is pending
- `stall_cycles`  out  STALL_W  saturating count of cycles with `pc_enable`=0

## Operation

- Load-use hazard (`luh`) is true when all of these hold: `mem_to_reg_e`, `reg_write_e`, `wr_reg_e`≠0, and `wr_reg_e` equals `rs_d` (with `uses_rs_d`) or equals `rt_d` (with `uses_rt_d`).
- HI/LO hazard (`hh`) is true when `muldiv_busy` and `hilo_use_d` are both high.
- Per-cycle priority; the first matching row wins:
  1. `luh` or `hh`: `pc_enable`=0, `haz_enable_fd`=0, `sig_clr_fd`=0, `sig_clr_de`=1. `branch_taken_d` is ignored because D re-evaluates next cycle.
  2. `branch_taken_d`: `pc_enable`=1, `haz_enable_fd`=1, `sig_clr_fd`=1, `sig_clr_de`=0. `imem_ready` is ignored because the fetched word is squashed anyway.
  3. `imem_ready`=0: `pc_enable`=0, `haz_enable_fd`=1, `sig_clr_fd`=1, `sig_clr_de`=0, which inserts a bubble into D.
  4. Otherwise: `pc_enable`=1, `haz_enable_fd`=1, both clears 0.
- Forwarding for operand A:
  - `fwd_a_e`=10 if `reg_write_m`, `wr_reg_m`≠0 and `wr_reg_m`==`rs_e`.
  - Else 01 if `reg_write_w`, `wr_reg_w`≠0 and `wr_reg_w`==`rs_e`.
  - Else 00.
  - M has priority over W.
- Forwarding for operand B (`fwd_b_e`) is identical, using `rt_e`.
- MULDIV FSM, states IDLE and BUSY, with a counter of width clog2(MULDIV_LAT):
  - IDLE with `muldiv_start_e`: go to BUSY and load count = MULDIV_LAT−1.
  - BUSY with count==0: go to IDLE. Otherwise decrement.
  - BUSY with `muldiv_start_e`: reload MULDIV_LAT−1 (restart) and stay in BUSY.
  - `muldiv_busy` equals (state==BUSY).
- Stall counter:
  - `stat_clr` forces 0 and has priority.
  - Otherwise the counter increments in every cycle with `pc_enable`=0.
  - It holds at all-ones and does not wrap.

## Timing

- Stall, clear and forwarding outputs are combinational from inputs and FSM state, with zero latency.
- The FSM and the counter update on the rising edge of `clk`.
- A start in cycle t gives `muldiv_busy`=1 in cycles t+1 through t+MULDIV_LAT, then 0 in cycle t+MULDIV_LAT+1.
- A load-use stall lasts exactly one cycle: the load advances to M, so `luh` falls.
- While `rst_n`=0, asynchronously:
  - FSM is IDLE, count=0, `stall_cycles`=0.
  - Outputs are forced to `pc_enable`=0, `haz_enable_fd`=1, `sig_clr_fd`=1, `sig_clr_de`=1, `fwd_*`=00, `muldiv_busy`=0.
- Reset mid-BUSY aborts the operation; there is no pending state after release.
- Cycles spent in reset are not counted by the stall counter.

## Structure

- Shared package `pipeline_pkg` holds:
  - `FWD_RF`=2'b00, `FWD_W`=2'b01, `FWD_M`=2'b10
  - `muldiv_state_t` enum {IDLE, BUSY}
  - `REG_ZERO`=5'd0
- Sub-module `muldiv_timer` contains the FSM and counter, with ports `clk`, `rst_n`, `start`, `busy`.
- The top level holds the hazard and forwarding logic and the stall counter.

## Test plan

- Load into $t0 in E, `add` reading $t0 in D → one cycle of `pc_enable`=0, `haz_enable_fd`=0, `sig_clr_de`=1; the next cycle is normal flow.
- `reg_write_m`=1 and `reg_write_w`=1, with `wr_reg_m`=`wr_reg_w`=`rs_e`=8 → `fwd_a_e`=10. Same with `wr_reg`=0 → 00.
- MULDIV_LAT=4, start pulse at cycle 10 → `muldiv_busy` high in cycles 11–14. `hilo_use_d` held high stalls exactly those 4 cycles.
- `branch_taken_d`=1 together with `imem_ready`=0 → `pc_enable`=1, `sig_clr_fd`=1. Add `luh` in the same cycle → the stall row wins.
- `imem_ready`=0 for 3 cycles → 3 F/D bubbles and `stall_cycles` goes 0→3. `stat_clr` together with a stall → 0.
- `rst_n` low mid-BUSY → `muldiv_busy`=0 immediately. Preset the counter near all-ones and stall → the counter saturates at 0xFFFF.
